// File: rtl/kernel_output_framer.sv
// Re-frames the one-result-per-pixel stream of a KxK window stage. Results whose window is
// incomplete are dropped; the rest leave as a raster with coordinates and line/frame markers.
module kernel_output_framer #(
    parameter int IMG_Width  = 8,
    parameter int IMG_Height = 8,
    parameter int K          = 7,
    parameter int Datawidth  = 8
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic [Datawidth-1:0]          In,
    input  logic                          Valid_IN,
    input  logic                          SOF_IN,
    output logic [Datawidth-1:0]          Out,
    output logic                          Valid_OUT,
    output logic [$clog2(IMG_Width)-1:0]  Out_Col,
    output logic [$clog2(IMG_Height)-1:0] Out_Row,
    output logic                          EOL,
    output logic                          EOF,
    output logic                          Frame_Done,
    output logic                          Frame_Abort
);

    localparam int CW = $clog2(IMG_Width);
    localparam int RW = $clog2(IMG_Height);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_Width - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_Height - 1);

    logic [0:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          restart;
    logic          accept;
    logic          abort;
    logic          emit;
    logic          at_eol;
    logic          last;

    // An SOF beat is always pixel (0,0), so it is classified with the counters forced to zero.
    always_comb begin
        restart = Valid_IN & SOF_IN;
        accept  = Valid_IN & (SOF_IN | (state == RUN));
        abort   = restart & (state == RUN);
        pos_col = restart ? '0 : col;
        pos_row = restart ? '0 : row;
        emit    = accept && (pos_col >= COL_FIRST) && (pos_row >= ROW_FIRST);
        at_eol  = (pos_col == COL_LAST);
        last    = at_eol && (pos_row == ROW_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            Out         <= '0;
            Valid_OUT   <= 1'b0;
            Out_Col     <= '0;
            Out_Row     <= '0;
            EOL         <= 1'b0;
            EOF         <= 1'b0;
            Frame_Done  <= 1'b0;
            Frame_Abort <= 1'b0;
        end else begin
            Valid_OUT   <= emit;
            EOL         <= emit && at_eol;
            EOF         <= emit && last && !abort;
            Frame_Done  <= emit && last && !abort;
            Frame_Abort <= abort;

            if (emit) begin
                Out     <= In;
                Out_Col <= pos_col - COL_FIRST;
                Out_Row <= pos_row - ROW_FIRST;
            end

            // Advance the raster position; the final pixel returns to IDLE for back-to-back frames.
            if (accept) begin
                if (last) begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end else begin
                    state <= RUN;
                    if (at_eol) begin
                        col <= '0;
                        row <= pos_row + 1'b1;
                    end else begin
                        col <= pos_col + 1'b1;
                        row <= pos_row;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_output_framer.sv
// Randomized scoreboard bench for kernel_output_framer; a frame-index reference model predicts
// every output event, and a negedge monitor pops and compares them as the DUT presents them.
module tb_kernel_output_framer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KS = 7;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          CLR;
    logic [DW-1:0] In;
    logic          Valid_IN;
    logic          SOF_IN;
    logic [DW-1:0] Out;
    logic          Valid_OUT;
    logic [2:0]    Out_Col;
    logic [2:0]    Out_Row;
    logic          EOL;
    logic          EOF;
    logic          Frame_Done;
    logic          Frame_Abort;

    kernel_output_framer #(
        .IMG_Width (W),
        .IMG_Height(H),
        .K         (KS),
        .Datawidth (DW)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .In         (In),
        .Valid_IN   (Valid_IN),
        .SOF_IN     (SOF_IN),
        .Out        (Out),
        .Valid_OUT  (Valid_OUT),
        .Out_Col    (Out_Col),
        .Out_Row    (Out_Row),
        .EOL        (EOL),
        .EOF        (EOF),
        .Frame_Done (Frame_Done),
        .Frame_Abort(Frame_Abort)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            valid;
        logic [DW-1:0] out;
        int            col;
        int            row;
        bit            eol;
        bit            eof;
        bit            done;
        bit            abort;
        int            due;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rst_edge = 1'b0;

    bit   m_in_frame = 1'b0;
    int   m_n = 0;

    logic [DW-1:0] hold_out = '0;
    int   hold_col = 0;
    int   hold_row = 0;

    int   obs_out[$];
    int   obs_done = 0;
    int   obs_abort = 0;
    int   exp_out[$];

    always @(posedge CLK) begin
        cyc++;
        rst_edge = !CLR;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a frame is just a running beat index; position is index mod/div width.
    task automatic modelBeat(input logic [DW-1:0] data, input bit sof);
        exp_t e;
        bit   abort;
        bit   take;
        int   c;
        int   r;
        bit   emit;
        bit   last;
        abort = 1'b0;
        take  = 1'b1;
        if (sof) begin
            abort      = m_in_frame;
            m_in_frame = 1'b1;
            m_n        = 0;
        end else if (!m_in_frame) begin
            take = 1'b0;
        end
        if (take) begin
            c    = m_n % W;
            r    = m_n / W;
            emit = (c >= KS - 1) && (r >= KS - 1);
            last = (m_n == W * H - 1);
            if (emit || abort) begin
                e.valid = emit;
                e.out   = data;
                e.col   = c - (KS - 1);
                e.row   = r - (KS - 1);
                e.eol   = emit && (c == W - 1);
                e.eof   = emit && last;
                e.done  = emit && last;
                e.abort = abort;
                e.due   = cyc + 1;
                sbq.push_back(e);
            end
            if (last) m_in_frame = 1'b0;
            m_n++;
        end
    endtask

    task automatic idleCycle();
        @(posedge CLK);
        #1;
        Valid_IN = 1'b0;
        SOF_IN   = 1'b0;
        In       = '0;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input bit sof, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 6 && $urandom_range(0, 1) == 0; g++) idleCycle();
        end
        @(posedge CLK);
        #1;
        Valid_IN = 1'b1;
        SOF_IN   = sof;
        In       = data;
        modelBeat(data, sof);
    endtask

    task automatic resetDut(input int cycles);
        @(posedge CLK);
        #1;
        CLR        = 1'b0;
        Valid_IN   = 1'b0;
        SOF_IN     = 1'b0;
        In         = '0;
        m_in_frame = 1'b0;
        m_n        = 0;
        repeat (cycles - 1) begin
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        CLR = 1'b1;
    endtask

    task automatic checkScenario(input string name, input int exp_done, input int exp_abort);
        int n;
        idleCycle();
        idleCycle();
        checkOutput({name, "_count"}, obs_out.size(), exp_out.size());
        n = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
        for (int i = 0; i < n; i++) checkOutput({name, "_out"}, obs_out[i], exp_out[i]);
        checkOutput({name, "_done"}, obs_done, exp_done);
        checkOutput({name, "_abort"}, obs_abort, exp_abort);
        obs_out.delete();
        obs_done  = 0;
        obs_abort = 0;
    endtask

    // Monitor: reset cycles must be all-zero; otherwise every flagged cycle pops one expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (rst_edge) begin
            checkOutput("rst_valid", Valid_OUT, 0);
            checkOutput("rst_out", Out, 0);
            checkOutput("rst_col", Out_Col, 0);
            checkOutput("rst_row", Out_Row, 0);
            checkOutput("rst_eol", EOL, 0);
            checkOutput("rst_eof", EOF, 0);
            checkOutput("rst_done", Frame_Done, 0);
            checkOutput("rst_abort", Frame_Abort, 0);
            hold_out = '0;
            hold_col = 0;
            hold_row = 0;
        end else begin
            if (Valid_OUT || EOL || EOF || Frame_Done || Frame_Abort) begin
                if (Valid_OUT) obs_out.push_back(int'(Out));
                if (Frame_Done) obs_done++;
                if (Frame_Abort) obs_abort++;
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_event", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("latency", cyc, e.due);
                    checkOutput("valid", Valid_OUT, e.valid);
                    checkOutput("eol", EOL, e.eol);
                    checkOutput("eof", EOF, e.eof);
                    checkOutput("frame_done", Frame_Done, e.done);
                    checkOutput("frame_abort", Frame_Abort, e.abort);
                    if (e.valid) begin
                        checkOutput("out", Out, e.out);
                        checkOutput("out_col", Out_Col, e.col);
                        checkOutput("out_row", Out_Row, e.row);
                        hold_out = e.out;
                        hold_col = e.col;
                        hold_row = e.row;
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                checkOutput("missing_event", 0, 1);
            end
            if (!Valid_OUT) begin
                checkOutput("hold_out", Out, hold_out);
                checkOutput("hold_col", Out_Col, hold_col);
                checkOutput("hold_row", Out_Row, hold_row);
            end
        end
    end

    initial begin
        CLR      = 1'b0;
        Valid_IN = 1'b0;
        SOF_IN   = 1'b0;
        In       = '0;
        repeat (3) @(posedge CLK);
        #1;
        CLR = 1'b1;
        idleCycle();

        $display("[TB] contiguous frame");
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), i == 0, 1'b0);
        exp_out = {54, 55, 62, 63};
        checkScenario("frame", 1, 0);

        $display("[TB] frame with random gaps");
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), i == 0, 1'b1);
        checkScenario("gaps", 1, 0);

        $display("[TB] beats without SOF then frame");
        for (int i = 0; i < 10; i++) applyStimulus(8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), i == 0, 1'b0);
        checkScenario("nosof", 1, 0);

        $display("[TB] SOF reissued mid-frame");
        for (int i = 0; i < 122; i++) applyStimulus(8'(i), (i == 0) || (i == 58), 1'b0);
        exp_out = {54, 55, 112, 113, 120, 121};
        checkScenario("abort", 1, 1);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 60; i++) applyStimulus(8'(i), i == 0, 1'b0);
        resetDut(2);
        for (int i = 0; i < 64; i++) applyStimulus(8'(i), i == 0, 1'b0);
        exp_out = {54, 55, 54, 55, 62, 63};
        checkScenario("reset", 1, 0);

        $display("[TB] back-to-back frames");
        for (int i = 0; i < 128; i++) applyStimulus(8'(i), (i == 0) || (i == 64), 1'b0);
        exp_out = {54, 55, 62, 63, 118, 119, 126, 127};
        checkScenario("b2b", 2, 0);

        $display("[TB] random frames with random gaps");
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) applyStimulus(8'($urandom_range(0, 255)), i == 0, 1'b1);
        end
        idleCycle();
        idleCycle();
        checkOutput("rand_done", obs_done, 3);
        checkOutput("rand_count", obs_out.size(), 12);

        idleCycle();
        checkOutput("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_output_framer.md
# kernel_output_framer

Consumer-side framer for the sliding-window datapath. It sits after the K×K line-buffer kernel and its arithmetic stage, and takes one result beat per accepted input pixel. It tracks the raster position of each beat and discards results whose window is incomplete or wraps across a row boundary. The surviving (IMG_Width−K+1)×(IMG_Height−K+1) results are re-emitted as a framed raster stream with coordinates and end-of-line/end-of-frame markers.

## Interface
- IMG_Width, 8: input image width in pixels (≥ K).
- IMG_Height, 8: input image height in rows (≥ K).
- K, 7: kernel size; a window is complete when col ≥ K−1 and row ≥ K−1.
- Datawidth, 8: result data width.
- CLK  input  1  clock, all logic on rising edge.
- CLR  input  1  reset, synchronous, active-low.
- In  input  Datawidth  result associated with the current input beat.
- Valid_IN  input  1  beat qualifier; counters advance only when high.
- SOF_IN  input  1  start-of-frame; meaningful only together with Valid_IN; marks the beat as pixel (0,0).
- Out  output  Datawidth  registered output result.
- Valid_OUT  output  1  Out/coordinates valid this cycle.
- Out_Col  output  $clog2(IMG_Width)  output column, 0..IMG_Width−K.
- Out_Row  output  $clog2(IMG_Height)  output row, 0..IMG_Height−K.
- EOL  output  1  high with the last valid result of an output row.
- EOF  output  1  high with the last valid result of the frame.
- Frame_Done  output  1  one-cycle pulse, coincident with EOF.
- Frame_Abort  output  1  one-cycle pulse when SOF_IN arrives mid-frame.

## Operation
- States: IDLE, RUN.
- IDLE:
  - Valid_IN & SOF_IN: the beat is position (0,0); go to RUN with col=1, row=0. If K=1, the beat is also emitted.
  - Valid_IN without SOF_IN: dropped, no output.
- RUN: each Valid_IN beat is at position (col,row).
  - Emit when col ≥ K−1 and row ≥ K−1, with Out_Col = col−(K−1) and Out_Row = row−(K−1).
  - Advance col. At col = IMG_Width−1, wrap col to 0 and increment row.
- Last beat, col = IMG_Width−1 and row = IMG_Height−1: emit with EOL=EOF=Frame_Done=1, clear counters, go to IDLE.
- EOL is asserted on every emitted beat with col = IMG_Width−1.
- Valid_IN low: counters hold, no output, no timeout.
- SOF_IN & Valid_IN while in RUN:
  - Current frame is abandoned and Frame_Abort pulses.
  - The beat is treated as (0,0) of a new frame; stay in RUN with col=1, row=0.
  - No EOF or Frame_Done is issued for the abandoned frame.
- Same-cycle SOF on the last beat of a frame: abort takes priority; no Frame_Done.
- Counters are compared against constants only; no arithmetic wraps beyond IMG_Width−1 / IMG_Height−1.

## Timing
- Latency: 1 cycle. Out, Valid_OUT, coordinates, EOL, EOF, Frame_Done and Frame_Abort are registered from the accepting edge.
- Throughput: one beat per cycle; back-to-back frames supported (SOF beat directly after the last beat is accepted from IDLE).
- Output field registers:
  - Valid_OUT, EOL, EOF, Frame_Done and Frame_Abort are 0 in any cycle without a qualifying event.
  - Out, Out_Col and Out_Row hold their last value when Valid_OUT=0.
- Reset (CLR=0 at a clock edge): state IDLE, col=row=0, and every output 0 on the next cycle. Reset mid-frame discards the frame silently, with no Frame_Abort.
- The first Valid_IN beat after CLR returns high is processed normally.

## Test plan
Defaults IMG_Width=8, IMG_Height=8, K=7 (2×2 outputs). Input In = beat index.

- One frame of 64 contiguous beats with SOF on beat 0:
  - Exactly 4 outputs, Out = 54, 55, 62, 63.
  - Coordinates (0,0), (1,0), (0,1), (1,1).
  - EOL on 55 and 63; EOF and Frame_Done on 63 only.
  - Each output one cycle after its input beat.
- Same frame with Valid_IN toggled randomly at 50%: identical output sequence and flags, only the cycle positions change.
- 10 beats without SOF from IDLE, then a normal frame: the first 10 beats produce no output; the frame then matches the first scenario.
- SOF reissued at beat 58 (after output 55):
  - Frame_Abort pulses one cycle later.
  - The new frame's outputs are relative to beat 58; no Frame_Done for the first frame.
- CLR=0 asserted at beat 60 for 2 cycles, then a fresh frame:
  - All outputs are 0 during reset.
  - No Frame_Done or Frame_Abort for the interrupted frame.
  - The fresh frame produces the 4 expected outputs.
- Two back-to-back frames (128 beats, SOF on beats 0 and 64): 8 outputs, two Frame_Done pulses, no Frame_Abort.
